// File: rtl/register_file_windowed.sv
// register_file_windowed
//   SPARC-style windowed integer register file: 8 globals plus NWIN
//   overlapping 16-register windows (outs + locals). The ins of window w
//   alias the outs of window (w+1) mod NWIN. Two combinational read ports
//   with write-through bypass, one write port, CWP with SAVE/RESTORE
//   rotation gated by WIM, and registered one-cycle trap pulses.
// Ports:
//   Clk, Reset      clock, synchronous active-high reset
//   RA, RB          logical read addresses -> Aout, Bout (zero latency)
//   RC, in, WE      logical write address, data, enable
//   Save, Restore   window rotation requests
//   WIM             window invalid mask
//   CWP             current window pointer
//   OvfTrap/UnfTrap one-cycle pulses for blocked SAVE / RESTORE
module register_file_windowed #(
  parameter int WIDTH = 32,
  parameter int NWIN  = 4,
  parameter int CWPW  = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       RA,
  input  logic [4:0]       RB,
  output logic [WIDTH-1:0] Aout,
  output logic [WIDTH-1:0] Bout,
  input  logic [4:0]       RC,
  input  logic [WIDTH-1:0] in,
  input  logic             WE,
  input  logic             Save,
  input  logic             Restore,
  input  logic [NWIN-1:0]  WIM,
  output logic [CWPW-1:0]  CWP,
  output logic             OvfTrap,
  output logic             UnfTrap
);

  localparam int NPHYS = 8 + 16 * NWIN;
  localparam int PW    = $clog2(NPHYS);

  logic [WIDTH-1:0] regs [NPHYS];
  logic [CWPW-1:0]  cwp_q;
  logic             ovf_q, unf_q;

  // Globals occupy physical 0..7 (r0 -> phys 0, never written); window
  // banks follow at 8 + w*16. The ins use the next window's outs bank,
  // which is what makes the overlap visible as a shared physical index.
  function automatic logic [PW-1:0] phys(input logic [4:0] r, input logic [CWPW-1:0] w);
    int wi, ri, idx;
    wi = int'(w);
    ri = int'(r);
    if (ri < 8)       idx = ri;
    else if (ri < 24) idx = 8 + wi * 16 + (ri - 8);
    else              idx = 8 + ((wi + 1) % NWIN) * 16 + (ri - 24);
    return PW'(idx);
  endfunction

  logic [PW-1:0] pa, pb, pc;
  logic          wr_en;

  assign pa    = phys(RA, cwp_q);
  assign pb    = phys(RB, cwp_q);
  assign pc    = phys(RC, cwp_q);
  assign wr_en = WE && (RC != 5'd0);

  // Bypass compares physical indices so an outs/ins alias also forwards.
  always_comb begin
    Aout = regs[pa];
    Bout = regs[pb];
    if (wr_en && pc == pa) Aout = in;
    if (wr_en && pc == pb) Bout = in;
    if (RA == 5'd0) Aout = '0;
    if (RB == 5'd0) Bout = '0;
  end

  // Rotation targets with explicit wrap so non-power-of-two NWIN works.
  logic [CWPW-1:0] cwp_dec, cwp_inc;
  assign cwp_dec = (cwp_q == '0) ? CWPW'(NWIN - 1) : cwp_q - CWPW'(1);
  assign cwp_inc = (cwp_q == CWPW'(NWIN - 1)) ? '0 : cwp_q + CWPW'(1);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NPHYS; i++) regs[i] <= '0;
      cwp_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      // Write uses the pre-update CWP, so it lands in the old window.
      if (wr_en) regs[pc] <= in;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      if (Save && !Restore) begin
        if (!WIM[cwp_dec]) cwp_q <= cwp_dec;
        else               ovf_q <= 1'b1;
      end else if (Restore && !Save) begin
        if (!WIM[cwp_inc]) cwp_q <= cwp_inc;
        else               unf_q <= 1'b1;
      end
    end
  end

  assign CWP     = cwp_q;
  assign OvfTrap = ovf_q;
  assign UnfTrap = unf_q;

endmodule

// File: tb/tb_register_file_windowed.sv
module tb_register_file_windowed;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [4:0]  RA, RB, RC;
  logic [31:0] Aout, Bout, in;
  logic        WE, Save, Restore;
  logic [3:0]  WIM;
  logic [1:0]  CWP;
  logic        OvfTrap, UnfTrap;

  register_file_windowed #(.WIDTH(32), .NWIN(4), .CWPW(2)) dut (
    .Clk(Clk), .Reset(Reset), .RA(RA), .RB(RB), .Aout(Aout), .Bout(Bout),
    .RC(RC), .in(in), .WE(WE), .Save(Save), .Restore(Restore), .WIM(WIM),
    .CWP(CWP), .OvfTrap(OvfTrap), .UnfTrap(UnfTrap)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic        chk_a, chk_b;
    logic [31:0] a, b;
    logic [1:0]  cwp;
    logic        ovf, unf;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: outputs are stable mid-cycle; pop whatever the stimulus
  // queued for this cycle and compare.
  always @(negedge Clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk_a) cmp({e.name, ".Aout"}, Aout, e.a);
      if (e.chk_b) cmp({e.name, ".Bout"}, Bout, e.b);
      cmp({e.name, ".CWP"}, 32'(CWP), 32'(e.cwp));
      cmp({e.name, ".OvfTrap"}, 32'(OvfTrap), 32'(e.ovf));
      cmp({e.name, ".UnfTrap"}, 32'(UnfTrap), 32'(e.unf));
    end
  end

  task automatic expect_now(input string name, input logic ca, input logic [31:0] a,
                            input logic cb, input logic [31:0] b, input logic [1:0] cwp,
                            input logic ovf, input logic unf);
    exp_t e;
    e.name = name; e.chk_a = ca; e.a = a; e.chk_b = cb; e.b = b;
    e.cwp = cwp; e.ovf = ovf; e.unf = unf;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge Clk); #1;
  endtask

  task automatic idle();
    WE = 0; Save = 0; Restore = 0; RA = 0; RB = 0; RC = 0; in = 0;
  endtask

  initial begin
    Reset = 1; WIM = 4'b0000; idle();
    cyc(); cyc();
    Reset = 0;

    // Reset clears storage; reset overrides write and Save.
    WE = 1; RC = 9; in = 32'hDEADBEEF; RA = 9;
    expect_now("wr_r9_bypass", 1, 32'hDEADBEEF, 1, 32'h0, 2'd0, 0, 0); cyc();
    idle(); RA = 9;
    expect_now("rd_r9", 1, 32'hDEADBEEF, 0, 0, 2'd0, 0, 0); cyc();
    Reset = 1; WE = 1; RC = 10; in = 32'h1; Save = 1; cyc();
    Reset = 0; idle(); RA = 9; RB = 10;
    expect_now("after_reset", 1, 32'h0, 1, 32'h0, 2'd0, 0, 0); cyc();

    // r0 and globals
    WE = 1; RC = 0; in = 32'h12345678; RA = 0; RB = 0;
    expect_now("r0_write", 1, 32'h0, 1, 32'h0, 2'd0, 0, 0); cyc();
    WE = 1; RC = 5; in = 32'hA5A5A5A5; RA = 0;
    expect_now("r0_after", 1, 32'h0, 0, 0, 2'd0, 0, 0); cyc();
    idle(); Save = 1; RA = 5;
    expect_now("g5_w0", 1, 32'hA5A5A5A5, 0, 0, 2'd0, 0, 0); cyc();
    idle(); Restore = 1; RA = 5;
    expect_now("g5_w3", 1, 32'hA5A5A5A5, 0, 0, 2'd3, 0, 0); cyc();

    // Overlap: out0 of window 0 is in0 of window 3
    idle(); WE = 1; RC = 8; in = 32'h11111111; Save = 1; RA = 8;
    expect_now("wrap_restore_out0", 1, 32'h11111111, 0, 0, 2'd0, 0, 0); cyc();
    idle(); RA = 24; RB = 8; Restore = 1;
    expect_now("overlap_w3", 1, 32'h11111111, 1, 32'h0, 2'd3, 0, 0); cyc();

    // Traps
    idle(); WIM = 4'b1000; Save = 1;
    expect_now("save_blocked", 0, 0, 0, 0, 2'd0, 0, 0); cyc();
    idle();
    expect_now("ovf_pulse", 0, 0, 0, 0, 2'd0, 1, 0); cyc();
    idle(); WIM = 4'b0010; Restore = 1;
    expect_now("ovf_drop", 0, 0, 0, 0, 2'd0, 0, 0); cyc();
    idle();
    expect_now("unf_pulse", 0, 0, 0, 0, 2'd0, 0, 1); cyc();
    idle(); WIM = 4'b1000; Save = 1;
    expect_now("b2b_req1", 0, 0, 0, 0, 2'd0, 0, 0); cyc();
    Save = 1;
    expect_now("b2b_req2", 0, 0, 0, 0, 2'd0, 1, 0); cyc();
    idle();
    expect_now("b2b_pulse2", 0, 0, 0, 0, 2'd0, 1, 0); cyc();
    WIM = 4'b0000;
    expect_now("b2b_end", 0, 0, 0, 0, 2'd0, 0, 0); cyc();

    // Bypass
    idle(); WE = 1; RC = 17; in = 32'hCAFEF00D; RA = 17; RB = 17;
    expect_now("bypass_ab", 1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 2'd0, 0, 0); cyc();
    idle(); RA = 17;
    expect_now("r17_stored", 1, 32'hCAFEF00D, 0, 0, 2'd0, 0, 0); cyc();
    idle(); WE = 1; RC = 8; in = 32'h0BADC0DE; RA = 9; RB = 8;
    expect_now("bypass_b_only", 1, 32'h0, 1, 32'h0BADC0DE, 2'd0, 0, 0); cyc();

    // Simultaneous requests, write with Save
    idle(); Save = 1; Restore = 1;
    expect_now("save_restore", 0, 0, 0, 0, 2'd0, 0, 0); cyc();
    idle(); Save = 1;
    expect_now("sr_noop", 0, 0, 0, 0, 2'd0, 0, 0); cyc();
    idle(); WE = 1; RC = 16; in = 32'h5; Save = 1; RA = 16;
    expect_now("wr_with_save", 1, 32'h5, 0, 0, 2'd3, 0, 0); cyc();
    idle(); RA = 16; Restore = 1;
    expect_now("new_win_l0", 1, 32'h0, 0, 0, 2'd2, 0, 0); cyc();
    idle(); RA = 16;
    expect_now("old_win_l0", 1, 32'h5, 0, 0, 2'd3, 0, 0); cyc();

    @(negedge Clk); #1;
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
